// File: rtl/intc.sv
// Memory-mapped interrupt controller: latches rising edges of src into PEND,
// gates them with MASK, and presents a registered irq plus a priority cause word.
module intc #(
  parameter int          NSRC = 8,
  parameter logic [31:0] BASE = 32'hFFFF_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [31:0]     memAddr,
  input  logic [31:0]     memWriteData,
  input  logic            MemRead,
  input  logic            MemWrite,
  output logic [31:0]     rdata,
  output logic            hit,
  output logic            irq
);

  typedef enum logic [1:0] {
    OFF_PEND  = 2'd0,
    OFF_MASK  = 2'd1,
    OFF_CLEAR = 2'd2,
    OFF_CAUSE = 2'd3
  } off_t;

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] active;
  logic            wr_mask;
  logic            wr_clear;
  off_t            off;
  logic            unused_bits;

  // Lowest enabled index wins; the word is all zero when nothing is active.
  function automatic logic [31:0] cause_word(input logic [NSRC-1:0] act);
    logic [31:0] w;
    w = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) w = {1'b1, 26'd0, 5'(i)};
    end
    return w;
  endfunction

  // Bus decode: byte offset bits [1:0] are ignored, MemRead only qualifies the system mux.
  assign hit         = (memAddr[31:4] == BASE[31:4]);
  assign off         = off_t'(memAddr[3:2]);
  assign wr_mask     = MemWrite && hit && (off == OFF_MASK);
  assign wr_clear    = MemWrite && hit && (off == OFF_CLEAR);
  assign unused_bits = ^{MemRead, memAddr[1:0], memWriteData};

  assign rise   = src & ~src_q;
  assign clr    = wr_clear ? memWriteData[NSRC-1:0] : '0;
  assign active = pend & mask;

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        OFF_PEND:  rdata = 32'(pend);
        OFF_MASK:  rdata = 32'(mask);
        OFF_CLEAR: rdata = '0;
        OFF_CAUSE: rdata = cause_word(active);
        default:   rdata = '0;
      endcase
    end
  end

  // State stage: edge detect, pending/mask update, and the single registered irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0;
      pend  <= '0;
      mask  <= '0;
      irq   <= 1'b0;
    end else begin
      src_q <= src;
      pend  <= rise | (pend & ~clr);
      if (wr_mask) mask <= memWriteData[NSRC-1:0];
      irq   <= |active;
    end
  end

endmodule

// File: tb/tb_intc.sv
// Bench for intc: directed scenarios followed by randomized bus/source traffic,
// all compared against a per-source behavioural model of the controller.
`timescale 1ns/1ps
module tb_intc;
  localparam int          NSRC = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NSRC-1:0] src = '0;
  logic [31:0]     memAddr = '0;
  logic [31:0]     memWriteData = '0;
  logic            MemRead = 1'b0;
  logic            MemWrite = 1'b0;
  logic [31:0]     rdata;
  logic            hit;
  logic            irq;

  always #5 clk = ~clk;

  intc #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .src(src), .memAddr(memAddr),
    .memWriteData(memWriteData), .MemRead(MemRead), .MemWrite(MemWrite),
    .rdata(rdata), .hit(hit), .irq(irq)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one flag per source for pending, enable and last sample.
  bit m_pend[NSRC];
  bit m_mask[NSRC];
  bit m_prev[NSRC];
  bit m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    if (a[31:4] != BASE[31:4]) return '0;
    case (a[3:2])
      2'd0: for (int i = 0; i < NSRC; i++) if (m_pend[i]) w |= (32'd1 << i);
      2'd1: for (int i = 0; i < NSRC; i++) if (m_mask[i]) w |= (32'd1 << i);
      2'd2: w = '0;
      default: begin
        for (int i = NSRC - 1; i >= 0; i--)
          if (m_pend[i] && m_mask[i]) w = 32'h8000_0000 | 32'(i);
      end
    endcase
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0;
    end
    m_irq = 0;
  endtask

  task automatic rst_cyc(input logic [NSRC-1:0] s);
    reset = 1'b1; src = s; MemWrite = 1'b0; MemRead = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk("rst_irq", 32'(irq), 32'(m_irq));
  endtask

  // One clock with the given bus/source inputs; bus outputs are checked pre-edge.
  task automatic cyc(input logic [NSRC-1:0] s, input logic [31:0] a,
                     input logic [31:0] d, input logic we);
    bit np[NSRC];
    bit nm[NSRC];
    bit ni;
    bit hm;
    bit clr;
    reset = 1'b0; src = s; memAddr = a; memWriteData = d;
    MemWrite = we; MemRead = 1'b1;
    #1;
    hm = (a[31:4] == BASE[31:4]);
    chk("bus_hit", 32'(hit), 32'(hm));
    chk("bus_rdata", rdata, m_read(a));
    ni = 0;
    for (int i = 0; i < NSRC; i++) begin
      ni = ni | (m_pend[i] & m_mask[i]);
      clr = we && hm && (a[3:2] == 2'd2) && d[i];
      np[i] = (s[i] && !m_prev[i]) || (m_pend[i] && !clr);
      nm[i] = (we && hm && (a[3:2] == 2'd1)) ? d[i] : m_mask[i];
    end
    @(posedge clk); #1;
    for (int i = 0; i < NSRC; i++) begin
      m_pend[i] = np[i]; m_mask[i] = nm[i]; m_prev[i] = s[i];
    end
    m_irq = ni;
    MemWrite = 1'b0; MemRead = 1'b0;
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memAddr = a; MemRead = 1'b1; MemWrite = 1'b0;
    #1;
    chk(tag, rdata, exp);
    MemRead = 1'b0;
  endtask

  task automatic checkall();
    for (int k = 0; k < 4; k++)
      rd("reg_model", BASE + 32'(4 * k), m_read(BASE + 32'(4 * k)));
  endtask

  initial begin
    logic [NSRC-1:0] s;
    logic [31:0]     a;
    logic [31:0]     d;
    logic            we;

    model_reset();

    // Reset held two cycles with all sources high.
    rst_cyc(8'hFF);
    rst_cyc(8'hFF);
    chk("rst_irq_lit", 32'(irq), 32'd0);
    rd("rst_pend", BASE + 32'h0, 32'h0);
    rd("rst_mask", BASE + 32'h4, 32'h0);

    // Sources high at release register as edges.
    cyc(8'hFF, BASE, 32'h0, 1'b0);
    rd("rel_pend", BASE + 32'h0, 32'h0000_00FF);
    chk("rel_irq", 32'(irq), 32'd0);
    cyc(8'hFF, BASE, 32'h0, 1'b0);
    chk("rel_irq2", 32'(irq), 32'd0);
    cyc(8'hFF, BASE + 32'h8, 32'hFF, 1'b1);
    rd("held_no_reset", BASE + 32'h0, 32'h0);
    cyc(8'h00, BASE, 32'h0, 1'b0);
    checkall();

    // Basic set / irq / cause / clear.
    cyc(8'h00, BASE + 32'h4, 32'h4, 1'b1);
    cyc(8'h04, BASE, 32'h0, 1'b0);
    rd("basic_pend", BASE + 32'h0, 32'h4);
    chk("basic_irq_k", 32'(irq), 32'd0);
    cyc(8'h00, BASE, 32'h0, 1'b0);
    chk("basic_irq_k1", 32'(irq), 32'd1);
    rd("basic_cause", BASE + 32'hC, 32'h8000_0002);
    cyc(8'h00, BASE + 32'h8, 32'h4, 1'b1);
    rd("basic_clr_pend", BASE + 32'h0, 32'h0);
    cyc(8'h00, BASE, 32'h0, 1'b0);
    chk("basic_irq_drop", 32'(irq), 32'd0);
    checkall();

    // Priority: lowest enabled index is reported.
    cyc(8'h00, BASE + 32'h4, 32'hFF, 1'b1);
    cyc(8'h28, BASE, 32'h0, 1'b0);
    rd("prio_cause", BASE + 32'hC, 32'h8000_0003);
    cyc(8'h28, BASE + 32'h8, 32'h8, 1'b1);
    rd("prio_cause2", BASE + 32'hC, 32'h8000_0005);
    cyc(8'h00, BASE + 32'h8, 32'hFF, 1'b1);
    cyc(8'h00, BASE, 32'h0, 1'b0);
    checkall();

    // Held level: clearing while held must not re-set.
    for (int c = 0; c < 10; c++) begin
      if (c == 3) cyc(8'h02, BASE + 32'h8, 32'h2, 1'b1);
      else        cyc(8'h02, BASE, 32'h0, 1'b0);
    end
    rd("held_pend", BASE + 32'h0, 32'h0);
    cyc(8'h00, BASE, 32'h0, 1'b0);
    cyc(8'h02, BASE, 32'h0, 1'b0);
    rd("reraise_pend", BASE + 32'h0, 32'h2);
    cyc(8'h00, BASE + 32'h8, 32'hFF, 1'b1);
    cyc(8'h00, BASE, 32'h0, 1'b0);

    // Collision: new edge on src[0] wins over a same-cycle clear.
    cyc(8'h01, BASE, 32'h0, 1'b0);
    cyc(8'h00, BASE, 32'h0, 1'b0);
    chk("coll_irq_pre", 32'(irq), 32'd1);
    cyc(8'h01, BASE + 32'h8, 32'h1, 1'b1);
    rd("coll_pend", BASE + 32'h0, 32'h1);
    chk("coll_irq", 32'(irq), 32'd1);
    cyc(8'h00, BASE, 32'h0, 1'b0);
    chk("coll_irq2", 32'(irq), 32'd1);

    // Decode: out-of-window access and masked-off upper MASK bits.
    rd("dec_mask_before", BASE + 32'h4, 32'hFF);
    cyc(8'h00, BASE + 32'h10, 32'hFFFF_FFFF, 1'b1);
    chk("dec_hit", 32'(hit), 32'd0);
    rd("dec_rdata", BASE + 32'h14, 32'h0);
    rd("dec_mask_after", BASE + 32'h4, 32'hFF);
    rd("dec_pend_after", BASE + 32'h0, 32'h1);
    cyc(8'h00, BASE + 32'h4, 32'hFFFF_FFFF, 1'b1);
    rd("mask_width", BASE + 32'h4, 32'h0000_00FF);
    rd("clear_read", BASE + 32'h8, 32'h0);
    checkall();

    // Randomized traffic against the model.
    s = '0;
    for (int it = 0; it < 600; it++) begin
      if (it % 150 == 75) begin
        rst_cyc(NSRC'($urandom));
        checkall();
      end
      s = s ^ (NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom));
      we = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d = d & 32'h0000_00FF & 32'($urandom);
      cyc(s, a, d, we);
      checkall();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
